// File: rtl/macc_array_pkg.sv
// macc_pkg: op_code encodings, rounding modes and control decode
// shared by the multi-lane MACC engine and its lanes.
`ifndef PRECISION_OP
`define PRECISION_OP 16
`endif
`ifndef PRECISION_ACC
`define PRECISION_ACC 32
`endif
`ifndef PRECISION_FRAC
`define PRECISION_FRAC 8
`endif

package macc_pkg;

  localparam logic [2:0] MACC_OP_MUL     = 3'd0;
  localparam logic [2:0] MACC_OP_SQR     = 3'd1;
  localparam logic [2:0] MACC_OP_MAC     = 3'd2;
  localparam logic [2:0] MACC_OP_SQR_ACC = 3'd3;
  localparam logic [2:0] MACC_OP_MADD    = 3'd4;
  localparam logic [2:0] MACC_OP_SQR_ADD = 3'd5;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  typedef struct packed {
    logic use_acc;
    logic use_add;
    logic clr;
  } macc_ctl_t;

  function automatic macc_ctl_t macc_decode(
    input logic [2:0] op,
    input logic       clr
  );
    macc_ctl_t c;
    c.use_acc = op[1];
    c.use_add = ~op[1] & op[2];
    c.clr     = clr;
    return c;
  endfunction

endpackage

// File: rtl/macc_array_lane.sv
// macc_lane: one lane's operand, product and accumulate stages
// plus output rounding/narrowing (saturating with MACC_ARRAY_SAT_EN).
module macc_lane
  import macc_pkg::*;
#(
  parameter int OP_0_WIDTH = `PRECISION_OP,
  parameter int OP_1_WIDTH = `PRECISION_OP,
  parameter int ACC_WIDTH  = `PRECISION_ACC,
  parameter int OUT_WIDTH  = `PRECISION_OP,
  parameter int FRAC_BITS  = `PRECISION_FRAC,
  parameter int ROUND_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_adv,
  input  logic                  i_sq1,
  input  macc_ctl_t             i_ctl2,
  input  logic                  i_v2,
  input  logic [OP_0_WIDTH-1:0] i_op_0,
  input  logic [OP_1_WIDTH-1:0] i_op_1,
  input  logic [ACC_WIDTH-1:0]  i_op_add,
  output logic [OUT_WIDTH-1:0]  o_out
);

  localparam logic [ACC_WIDTH:0] RND =
    (ROUND_MODE == ROUND_HALF_UP) ?
    ((ACC_WIDTH+1)'(1) << (FRAC_BITS-1)) : '0;

  logic [OP_0_WIDTH-1:0]       r_a;
  logic [OP_1_WIDTH-1:0]       r_b;
  logic [ACC_WIDTH-1:0]        r_add1;
  logic [ACC_WIDTH-1:0]        r_add2;
  logic signed [ACC_WIDTH-1:0] r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0]        r_out;

  logic signed [ACC_WIDTH-1:0] w_ax;
  logic signed [ACC_WIDTH-1:0] w_bx;
  logic signed [ACC_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_addend;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH:0]   w_rnd;
  logic [OUT_WIDTH-1:0]        w_nar;

  assign w_ax = {{(ACC_WIDTH-OP_0_WIDTH){r_a[OP_0_WIDTH-1]}}, r_a};
  assign w_bx = i_sq1 ? w_ax :
    {{(ACC_WIDTH-OP_1_WIDTH){r_b[OP_1_WIDTH-1]}}, r_b};
  assign w_prod = w_ax * w_bx;

  // clear only drops the accumulator term; op_add still applies
  always_comb begin
    w_addend = '0;
    if (i_ctl2.use_acc)
      w_addend = i_ctl2.clr ? '0 : r_acc;
    else if (i_ctl2.use_add)
      w_addend = r_add2 <<< FRAC_BITS;
  end

  assign w_sum = r_prod + w_addend;
  assign w_rnd = {w_sum[ACC_WIDTH-1], w_sum} + RND;

`ifdef MACC_ARRAY_SAT_EN
  logic signed [ACC_WIDTH:0] w_shr;
  logic                      w_fit;
  assign w_shr = w_rnd >>> FRAC_BITS;
  assign w_fit = (&w_shr[ACC_WIDTH:OUT_WIDTH-1]) |
                 (~|w_shr[ACC_WIDTH:OUT_WIDTH-1]);
  assign w_nar = w_fit ? w_shr[OUT_WIDTH-1:0] :
    w_shr[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                       {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
  assign w_nar = OUT_WIDTH'(w_rnd >>> FRAC_BITS);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_add1 <= '0;
      r_add2 <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_out  <= '0;
    end else if (i_adv) begin
      r_a    <= i_op_0;
      r_b    <= i_op_1;
      r_add1 <= i_op_add;
      r_add2 <= r_add1;
      r_prod <= w_prod;
      if (i_v2) begin
        r_acc <= w_sum;
        r_out <= w_nar;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/macc_array.sv
// macc_array: NUM_LANES MACC lanes behind one valid/ready stream.
// Define MACC_ARRAY_SAT_EN for saturating output narrowing.
module macc_array
  import macc_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int OP_0_WIDTH = `PRECISION_OP,
  parameter int OP_1_WIDTH = `PRECISION_OP,
  parameter int ACC_WIDTH  = `PRECISION_ACC,
  parameter int OUT_WIDTH  = `PRECISION_OP,
  parameter int FRAC_BITS  = `PRECISION_FRAC,
  parameter int ROUND_MODE = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      op_code,
  input  logic                            clear,
  input  logic [NUM_LANES*OP_0_WIDTH-1:0] op_0,
  input  logic [NUM_LANES*OP_1_WIDTH-1:0] op_1,
  input  logic [NUM_LANES*ACC_WIDTH-1:0]  op_add,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*OUT_WIDTH-1:0]  out
);

  logic      w_stall;
  logic      w_adv;
  logic      r_v1;
  logic      r_v2;
  logic      r_v3;
  logic      r_sq1;
  macc_ctl_t r_ctl1;
  macc_ctl_t r_ctl2;

  // whole pipeline freezes while a result waits downstream
  assign w_stall  = r_v3 & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = ~w_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_sq1  <= 1'b0;
      r_ctl1 <= '0;
      r_ctl2 <= '0;
    end else if (w_adv) begin
      r_v1   <= in_valid;
      r_v2   <= r_v1;
      r_v3   <= r_v2;
      r_sq1  <= op_code[0];
      r_ctl1 <= macc_decode(op_code, clear);
      r_ctl2 <= r_ctl1;
    end
  end

  assign out_valid = r_v3;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    macc_lane #(
      .OP_0_WIDTH (OP_0_WIDTH),
      .OP_1_WIDTH (OP_1_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ROUND_MODE (ROUND_MODE)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_adv    (w_adv),
      .i_sq1    (r_sq1),
      .i_ctl2   (r_ctl2),
      .i_v2     (r_v2),
      .i_op_0   (op_0[g*OP_0_WIDTH +: OP_0_WIDTH]),
      .i_op_1   (op_1[g*OP_1_WIDTH +: OP_1_WIDTH]),
      .i_op_add (op_add[g*ACC_WIDTH +: ACC_WIDTH]),
      .o_out    (out[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_macc_array.sv
// tb_macc_array: scoreboard bench for macc_array, with a truncating
// and a round-half-up instance driven by the same stream.
module tb_macc_array;
  import macc_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic [2:0]   op_code;
  logic         clear;
  logic [63:0]  op_0;
  logic [63:0]  op_1;
  logic [127:0] op_add;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [63:0]  o_t;
  logic         in_ready_r;
  logic         out_valid_r;
  logic [63:0]  o_r;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] t;
    logic [63:0] r;
  } exp_t;

  exp_t sbq[$];
  logic signed [31:0] m_acc [4];

  macc_array #(.ROUND_MODE(ROUND_TRUNC)) dut_t (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .clear(clear),
    .op_0(op_0), .op_1(op_1), .op_add(op_add),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(o_t)
  );

  macc_array #(.ROUND_MODE(ROUND_HALF_UP)) dut_r (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_r),
    .op_code(op_code), .clear(clear),
    .op_0(op_0), .op_1(op_1), .op_add(op_add),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .out(o_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk16(
    input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] pk32(
    input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0] conv(
    input logic signed [31:0] s, input int rm);
    logic signed [32:0] t;
    t = {s[31], s} + 33'(rm != 0 ? 128 : 0);
    t = t >>> 8;
`ifdef MACC_ARRAY_SAT_EN
    if (t > 33'sd32767)  return 16'h7FFF;
    if (t < -33'sd32768) return 16'h8000;
`endif
    return t[15:0];
  endfunction

  // lane0 expectations are hand values; lanes 1-3 use the model
  task automatic beat(input logic [2:0] op, input logic clr,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [127:0] ad,
                      input logic [15:0] h0t, input logic [15:0] h0r);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    op_code  = op;
    clear    = clr;
    op_0     = a;
    op_1     = b;
    op_add   = ad;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int l = 0; l < 4; l++) begin
      logic signed [15:0] x, y;
      logic signed [31:0] p, ad32, addn, s;
      x = a[l*16 +: 16];
      y = op[0] ? x : b[l*16 +: 16];
      p = 32'(x) * 32'(y);
      ad32 = ad[l*32 +: 32];
      addn = 32'sd0;
      if (op[1]) addn = clr ? 32'sd0 : m_acc[l];
      else if (op[2]) addn = ad32 <<< 8;
      s = p + addn;
      m_acc[l] = s;
      e.t[l*16 +: 16] = (l == 0) ? h0t : conv(s, 0);
      e.r[l*16 +: 16] = (l == 0) ? h0r : conv(s, 1);
    end
    sbq.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [63:0] held;
  bit          stalled = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_trunc", o_t, e.t);
        chk("out_round", o_r, e.r);
        chk("valid_round", 64'(out_valid_r), 64'd1);
      end
    end
    if (out_valid && !out_ready) begin
      chk("in_ready_stall", 64'(in_ready), 64'd0);
      if (stalled) chk("out_stable", o_t, held);
      held    = o_t;
      stalled = 1'b1;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

  logic [15:0] ov_h;

  initial begin
`ifdef MACC_ARRAY_SAT_EN
    ov_h = 16'h7FFF;
`else
    ov_h = 16'hFE00;
`endif
    for (int l = 0; l < 4; l++) m_acc[l] = '0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    op_code   = '0;
    clear     = 1'b0;
    op_0      = '0;
    op_1      = '0;
    op_add    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_in_ready_r", 64'(in_ready_r), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", o_t, 64'd0);
    idle(1);

    beat(MACC_OP_MUL, 1'b0,
         pk16(16'h0200, 16'hFE00, 16'h0100, 16'h7FFF),
         pk16(16'h0180, 16'h0180, 16'h8000, 16'h0001),
         '0, 16'h0300, 16'h0300);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("latency", 64'(out_valid), 64'(k == 2));
    end
    idle(2);

    for (int i = 0; i < 4; i++)
      beat(MACC_OP_MAC, i == 0,
           pk16(16'h0100, 16'hFF80, 16'h0300, 16'h8000),
           pk16(16'h0100, 16'hFF80, 16'hFF00, 16'h0001),
           '0, 16'((i + 1) * 256), 16'((i + 1) * 256));
    idle(4);

    for (int i = 0; i < 2; i++)
      beat(MACC_OP_SQR_ADD, i == 1,
           pk16(16'hFF00, 16'h0080, 16'h0200, 16'hFFFF),
           pk16(16'h7FFF, 16'h1234, 16'h0000, 16'h7FFF),
           pk32(32'h200, 32'hFFFFFF00, 32'h0, 32'h7FFF),
           16'h0300, 16'h0300);
    beat(MACC_OP_MUL, 1'b0,
         pk16(16'h0001, 16'hFFFF, 16'h0003, 16'h0001),
         pk16(16'h0080, 16'h0080, 16'h0080, 16'h0040),
         '0, 16'h0000, 16'h0001);
    beat(MACC_OP_MUL, 1'b0,
         pk16(16'h7F00, 16'h8100, 16'h0100, 16'h0000),
         pk16(16'h0200, 16'h0200, 16'h0100, 16'h1234),
         '0, ov_h, ov_h);
    idle(5);

    fork
      for (int i = 0; i < 8; i++)
        beat(MACC_OP_MAC, i == 0,
             pk16(16'h0100, 16'h0200, 16'hFF00, 16'h0080),
             pk16(16'h0100, 16'h0200, 16'h0100, 16'h0080),
             '0, 16'((i + 1) * 256), 16'((i + 1) * 256));
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(6);

    for (int i = 0; i < 4; i++)
      beat(MACC_OP_MAC, i == 0,
           pk16(16'h0100, 16'h0200, 16'h0300, 16'h0400),
           pk16(16'h0100, 16'h0100, 16'h0100, 16'h0100),
           '0, 16'((i + 1) * 256), 16'((i + 1) * 256));
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out", o_t, 64'd0);
    chk("async_rst_out_r", o_r, 64'd0);
    sbq.delete();
    for (int l = 0; l < 4; l++) m_acc[l] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    beat(MACC_OP_MAC, 1'b0,
         pk16(16'h0100, 16'hFF00, 16'h0200, 16'h0010),
         pk16(16'h0100, 16'h0300, 16'h0200, 16'h0010),
         '0, 16'h0100, 16'h0100);
    idle(8);
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/macc_array.md
Name: macc_array

Overview:
- Parametrised multi-lane fixed-point multiply-accumulate engine: NUM_LANES independent MACC lanes sharing one op_code, clear and valid/ready stream.
- Successor of the single-lane MACC primitive; adds valid/ready flow control, a configurable lane count, output rounding and optional output saturation.
- Sits between the operand buffers and the output/activation stage of the DNN PE array.

Parameters:
- NUM_LANES, 4, number of parallel MACC lanes
- OP_0_WIDTH, `PRECISION_OP, signed width of operand 0 per lane
- OP_1_WIDTH, `PRECISION_OP, signed width of operand 1 per lane
- ACC_WIDTH, `PRECISION_ACC, signed accumulator width per lane; must be >= OP_0_WIDTH+OP_1_WIDTH
- OUT_WIDTH, `PRECISION_OP, signed output width per lane
- FRAC_BITS, `PRECISION_FRAC, fractional bits of operands, op_add and out; must be >= 1
- ROUND_MODE, 0, 0 = truncate (arithmetic shift), 1 = round half up

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat this cycle
- op_code  in  3  operation for this beat (encoding below)
- clear  in  1  beat starts a fresh accumulation
- op_0  in  NUM_LANES*OP_0_WIDTH  lane i at [i*OP_0_WIDTH +: OP_0_WIDTH]
- op_1  in  NUM_LANES*OP_1_WIDTH  same packing; ignored for square ops
- op_add  in  NUM_LANES*ACC_WIDTH  addend in output format (FRAC_BITS fractional bits)
- out_valid  out  1  out holds a result
- out_ready  in  1  downstream accepts the result
- out  out  NUM_LANES*OUT_WIDTH  per-lane results, same packing

Behaviour:
- Reset (reset_n low, asynchronous): every pipeline register, accumulator and out_valid go to 0, and out goes to 0. in_ready is 1 as soon as reset_n is high.
- op_code encoding:
  - bit0 = square (op_1 is replaced by op_0).
  - bit1 = accumulate (addend = the lane's accumulator).
  - bit2 with bit1=0 = add (addend = op_add <<< FRAC_BITS).
  - bits[2:1]=00 is multiply (addend 0). 11 behaves as accumulate.
- Three-stage pipeline; latency is exactly 3 cycles from acceptance to out_valid when there is no backpressure.
  - S1: register operands, op_code, clear and op_add.
  - S2: full-width signed product.
  - S3: acc <= product + addend, written back to the lane accumulator.
- Accepting a beat: a beat is accepted when in_valid && in_ready. Stages without a valid beat carry a bubble. Bubbles never modify accumulators.
- Backpressure: stall = out_valid && !out_ready. in_ready = !stall. During a stall the entire pipeline holds: no register advances, the accumulators are unchanged and out is stable. Throughput is one beat per cycle when out_ready is held high.
- clear: clear=1 on an accepted beat forces the addend to 0 at S3 for that beat, whatever the op_code. The beat's result is its product alone (plus op_add for add ops), and that result becomes the new accumulator.
- Accumulate immediately after clear: the next beat sees the accumulator written by the clear beat (back-to-back forwarding at S3, no bubble).
- Accumulator arithmetic: wraps two's-complement in ACC_WIDTH. The product is sign-extended to ACC_WIDTH.
- Output conversion per lane: out = (acc + rnd) >>> FRAC_BITS, then narrowed to OUT_WIDTH.
  - rnd = 1<<(FRAC_BITS-1) when ROUND_MODE=1, otherwise 0.
  - The rounding add is done at ACC_WIDTH+1 bits.
  - Conversion is registered in S3 alongside acc; it adds no extra latency.
- Lanes are fully independent apart from the shared control.

Optional Feature:
- Macro: MACC_ARRAY_SAT_EN.
- Defined: the narrowing to OUT_WIDTH saturates to the range [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1]. The accumulator itself still wraps.
- Not defined: the narrowing keeps the low OUT_WIDTH bits (wrap).

Decomposition:
- Shared package macc_pkg:
  - op_code localparams: MACC_OP_MUL=3'd0, MACC_OP_SQR=3'd1, MACC_OP_MAC=3'd2, MACC_OP_SQR_ACC=3'd3, MACC_OP_MADD=3'd4, MACC_OP_SQR_ADD=3'd5.
  - ROUND_TRUNC/ROUND_HALF_UP constants.
- Sub-module macc_lane: one lane's datapath and accumulator, with a shared advance/valid input.
- macc_array: owns the valid pipeline, stall logic and the generate loop over lanes.

Test Plan:
Defaults: 16/16/32/16 widths, FRAC_BITS=8, NUM_LANES=4.
- Multiply: lane0 op_0=0x0200, op_1=0x0180, op_code=0, in_valid for 1 cycle -> out_valid exactly 3 cycles later, lane0 out=0x0300.
- MAC stream: 4 beats of op_code=2 with op_0=op_1=0x0100 and clear on beat 1 -> outputs 0x0100, 0x0200, 0x0300, 0x0400 on consecutive cycles.
- Square-add: op_0=0xFF00, op_add=0x00000200, op_code=5 -> out=0x0300; op_1 = 0x7FFF has no effect.
- Rounding: op_0=0x0001, op_1=0x0080, op_code=0 -> out=0x0000 with ROUND_MODE=0, out=0x0001 with ROUND_MODE=1.
- Overflow: op_0=0x7F00, op_1=0x0200 -> out=0x7FFF with MACC_ARRAY_SAT_EN, out=0xFE00 without it.
- Backpressure and reset:
  - Drop out_ready for 4 cycles during a MAC stream -> in_ready low, out stable, and the accumulated totals match the no-stall run.
  - Pull reset_n low mid-stream -> out_valid=0 and out=0 immediately, no clock edge needed. After release, the first MAC without clear starts from 0.
